if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the program counter, drives the instruction-memory read address, and registers the fetched word into the IF/ID pipeline register consumed by the decode/control stage. Handles load-use stalls, taken-branch/jump redirects (with bubble insertion), and the `halt` opcode (6'b111111), which freezes fetch until reset or an older redirect cancels it.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `IM_ADDR_W`, 8, instruction-memory word-address width.

- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit hold request; freezes PC and IF/ID.
- `redirect_valid`  in  1  taken branch or jump resolved downstream this cycle.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 00).
- `imem_addr`  out  IM_ADDR_W  word address to instruction ROM, = `pc[IM_ADDR_W+1:2]`.
- `imem_data`  in  32  combinational ROM read data for `imem_addr`.
- `pc`  out  32  current fetch PC.
- `if_id_instr`  out  32  registered instruction to decode.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1  fetch frozen by halt.
- `fetch_cnt`  out  32  count of instructions latched with valid=1.

## Operation
- States: RUN, HALTED. Reset → RUN.
- Per-edge priority: `rst` > `redirect_valid` > `stall` > HALTED > RUN-normal.
- Redirect (any state, regardless of `stall`): `pc` ← {redirect_pc[31:2],2'b00}; IF/ID ← bubble (instr 0, pc4 0, valid 0); state ← RUN; `halted` ← 0. Redirect comes from an older instruction, so it cancels a pending halt.
- Stall (no redirect): `pc`, IF/ID, state, `fetch_cnt` all hold.
- HALTED (no redirect, no stall): `pc` holds; IF/ID ← bubble each edge.
- RUN-normal: IF/ID ← {imem_data, pc+4, valid 1}; `fetch_cnt` += 1.
  - If imem_data[31:26] == 6'b111111: `pc` holds (points at halt word), state ← HALTED, `halted` ← 1 on the same edge.
  - Else `pc` ← pc+4.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 = 0. `fetch_cnt` wraps at 2^32. `imem_addr` truncates upper PC bits (ROM aliasing is intentional).
- Instruction 32'h0000_0000 (sll $0) is the bubble encoding; decode treats it as a harmless R-type.

## Timing
- Reset values: `pc`=RESET_PC, `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0, `halted`=0, `fetch_cnt`=0, state RUN. Reset asserted mid-operation takes effect immediately (asynchronous), overriding stall/redirect.
- `imem_addr` is combinational from `pc`; ROM data must settle within the same cycle.
- Fetch latency: instruction at `pc` appears on `if_id_instr` after the next rising edge (1 cycle).
- Redirect sampled at edge N: `pc`=target after N; IF/ID bubble after N; target instruction in IF/ID after N+1.
- Stall sampled at edge N: outputs after N equal those before N. Stall held k cycles = k-cycle freeze.
- Redirect and stall same cycle: redirect wins; stall ignored that edge.
- Halt fetched at edge N: `halted`=1 and halt word in IF/ID after N; bubble in IF/ID after N+1 onward.

## Test plan
- Reset, ROM = addi, addi, lw, sw at 0x0..0xC: after edges 1–4, `if_id_pc4` = 4, 8, 12, 16, `if_id_valid`=1, `fetch_cnt`=4.
- Stall high 2 cycles after 2nd fetch: `pc`=0x8, `if_id_instr`=ROM[1] held for both edges; `fetch_cnt` stays 2; resumes with ROM[2].
- Redirect to 0x43 at `pc`=0x10: next edge `pc`=0x40, `if_id_valid`=0; following edge `if_id_instr`=ROM[0x10], `if_id_pc4`=0x44.
- Halt (0xFC000000) at 0x8: after its edge `halted`=1, `pc`=0x8; subsequent edges `if_id_valid`=0, `pc` stays 0x8, `fetch_cnt`=3 constant.
- Halt pending plus redirect_valid to 0x20 with stall=1: `halted`→0, `pc`=0x20, state RUN, IF/ID bubble.
- RESET_PC=32'hFFFF_FFFC: first fetch gives `if_id_pc4`=0, `pc`=0; assert `rst` mid-cycle → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM addressing and the IF/ID pipeline register.
// Handles stalls, downstream redirects (with bubble insertion) and the halt opcode.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IM_ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic [IM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]          imem_data,
   output logic [31:0]          pc,
   output logic [31:0]          if_id_instr,
   output logic [31:0]          if_id_pc4,
   output logic                 if_id_valid,
   output logic                 halted,
   output logic [31:0]          fetch_cnt
);

   typedef enum logic {RUN, HALTED} state_e;

   localparam logic [5:0] OP_HALT = 6'b111111;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         cnt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (redirect_valid) begin
         // Redirect comes from an older instruction, so it also cancels a pending halt.
         pc_d    = {redirect_pc[31:2], 2'b00};
         instr_d = 32'h0;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
         state_d = RUN;
      end else if (stall) begin
         state_d = state_q;
      end else if (state_q == HALTED) begin
         instr_d = 32'h0;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
      end else begin
         instr_d = imem_data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         cnt_d   = cnt_q + 32'd1;
         if (imem_data[31:26] == OP_HALT) state_d = HALTED;
         else                             pc_d    = pc_plus4;
      end
   end

   assign imem_addr   = pc_q[IM_ADDR_W+1:2];
   assign pc          = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign halted      = (state_q == HALTED);
   assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for fetch/stall/redirect, hand sequences for halt,
// redirect-cancels-halt, PC wrap and asynchronous reset.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst, stall, rv;
   logic [31:0] rpc;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data, pc, instr, pc4, cnt;
   logic        valid, halted;

   logic        rst2;
   logic [7:0]  imem_addr2;
   logic [31:0] imem_data2, pc2, instr2, pc42, cnt2;
   logic        valid2, halted2;

   logic [31:0] rom [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_data  = rom[imem_addr];
   assign imem_data2 = rom[imem_addr2];

   if_stage #(.RESET_PC(32'h0000_0000), .IM_ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
      .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc), .if_id_instr(instr),
      .if_id_pc4(pc4), .if_id_valid(valid), .halted(halted), .fetch_cnt(cnt));

   if_stage #(.RESET_PC(32'hFFFF_FFFC), .IM_ADDR_W(8)) dut_wrap (
      .clk(clk), .rst(rst2), .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_addr(imem_addr2), .imem_data(imem_data2), .pc(pc2), .if_id_instr(instr2),
      .if_id_pc4(pc42), .if_id_valid(valid2), .halted(halted2), .fetch_cnt(cnt2));

   typedef struct {
      logic        st;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        v;
      logic        h;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic [31:0] e_pc4, input logic e_v, input logic e_h,
                          input logic [31:0] e_cnt);
      chk({tag, ".pc"},    pc,    e_pc);
      chk({tag, ".instr"}, instr, e_instr);
      chk({tag, ".pc4"},   pc4,   e_pc4);
      chk({tag, ".valid"}, {31'h0, valid},  {31'h0, e_v});
      chk({tag, ".halted"},{31'h0, halted}, {31'h0, e_h});
      chk({tag, ".cnt"},   cnt,   e_cnt);
      chk({tag, ".imem_addr"}, {24'h0, imem_addr}, {24'h0, e_pc[9:2]});
   endtask

   task automatic step(input logic s, input logic r, input logic [31:0] t);
      stall = s; rv = r; rpc = t;
      @(posedge clk); #1;
      stall = 1'b0; rv = 1'b0; rpc = 32'h0;
   endtask

   localparam logic [31:0] I0 = 32'h2008_0001, I1 = 32'h2009_0002, I2 = 32'h8D0A_0000,
                           I3 = 32'hAD0A_0004, I16 = 32'h3C0B_1234, HALT = 32'hFC00_0000;

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0020 + i;
      rom[0] = I0; rom[1] = I1; rom[2] = I2; rom[3] = I3; rom[16] = I16;
      rom[255] = 32'h2400_0055;

      //         st    rv    rpc           pc            instr  pc4           v     h     cnt
      tbl[0] = '{1'b0, 1'b0, 32'h0,        32'h04,       I0,    32'h04,       1'b1, 1'b0, 32'd1};
      tbl[1] = '{1'b0, 1'b0, 32'h0,        32'h08,       I1,    32'h08,       1'b1, 1'b0, 32'd2};
      tbl[2] = '{1'b1, 1'b0, 32'h0,        32'h08,       I1,    32'h08,       1'b1, 1'b0, 32'd2};
      tbl[3] = '{1'b1, 1'b0, 32'h0,        32'h08,       I1,    32'h08,       1'b1, 1'b0, 32'd2};
      tbl[4] = '{1'b0, 1'b0, 32'h0,        32'h0C,       I2,    32'h0C,       1'b1, 1'b0, 32'd3};
      tbl[5] = '{1'b0, 1'b0, 32'h0,        32'h10,       I3,    32'h10,       1'b1, 1'b0, 32'd4};
      tbl[6] = '{1'b0, 1'b1, 32'h43,       32'h40,       32'h0, 32'h0,        1'b0, 1'b0, 32'd4};
      tbl[7] = '{1'b0, 1'b0, 32'h0,        32'h44,       I16,   32'h44,       1'b1, 1'b0, 32'd5};
      tbl[8] = '{1'b1, 1'b1, 32'h7,        32'h04,       32'h0, 32'h0,        1'b0, 1'b0, 32'd5};
      tbl[9] = '{1'b0, 1'b0, 32'h0,        32'h08,       I1,    32'h08,       1'b1, 1'b0, 32'd6};

      rst = 1'b1; rst2 = 1'b1; stall = 1'b0; rv = 1'b0; rpc = 32'h0;
      #12 rst = 1'b0;
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].st, tbl[i].rv, tbl[i].rpc);
         chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].pc4,
                 tbl[i].v, tbl[i].h, tbl[i].cnt);
      end

      // Halt word at 0x8.
      rom[2] = HALT;
      #3 rst = 1'b1; #1;
      chk_all("rst_async", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk_all("halt_edge", 32'h08, HALT, 32'h0C, 1'b1, 1'b1, 32'd3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk_all($sformatf("halted%0d", i), 32'h08, 32'h0, 32'h0, 1'b0, 1'b1, 32'd3);
      end
      step(1'b1, 1'b0, 32'h0);
      chk_all("halt_stall", 32'h08, 32'h0, 32'h0, 1'b0, 1'b1, 32'd3);
      step(1'b1, 1'b1, 32'h20);
      chk_all("halt_redir", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);
      step(1'b0, 1'b0, 32'h0);
      chk_all("after_redir", 32'h24, rom[8], 32'h24, 1'b1, 1'b0, 32'd4);

      // Reset wins over a simultaneous redirect, asynchronously.
      rv = 1'b1; rpc = 32'h80; #2 rst = 1'b1; #1;
      chk_all("rst_over_redir", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      rv = 1'b0;

      // PC wrap from RESET_PC = 0xFFFF_FFFC.
      @(negedge clk); rst2 = 1'b0;
      chk("wrap.reset_pc", pc2, 32'hFFFF_FFFC);
      chk("wrap.imem_addr", {24'h0, imem_addr2}, 32'h0000_00FF);
      @(posedge clk); #1;
      chk("wrap.pc", pc2, 32'h0);
      chk("wrap.pc4", pc42, 32'h0);
      chk("wrap.instr", instr2, 32'h2400_0055);
      chk("wrap.valid", {31'h0, valid2}, 32'h1);
      chk("wrap.cnt", cnt2, 32'd1);
      #3 rst2 = 1'b1; #1;
      chk("wrap.rst_pc", pc2, 32'hFFFF_FFFC);
      chk("wrap.rst_instr", instr2, 32'h0);
      chk("wrap.rst_pc4", pc42, 32'h0);
      chk("wrap.rst_valid", {31'h0, valid2}, 32'h0);
      chk("wrap.rst_halted", {31'h0, halted2}, 32'h0);
      chk("wrap.rst_cnt", cnt2, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
